// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c master arbiter slice: bus widths, arbiter
// state encoding and the default watchdog limit.
package i2c_pkg;

   localparam int I2C_ADDR_W             = 7;
   localparam int I2C_DATA_W             = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } arb_state_e;

   // Index width for n items, never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping,
// returned as a one-hot grant plus its binary index.
module rr_arbiter
   import i2c_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   int   pos_s;
   logic hit_s;

   // Scan requests starting at the pointer; the first hit wins.
   always_comb begin
      gnt   = {N_REQ{1'b0}};
      idx   = {IDX_W{1'b0}};
      valid = 1'b0;
      pos_s = 0;
      hit_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         pos_s      = (int'(ptr) + i) % N_REQ;
         hit_s      = req[pos_s] & ~valid;
         gnt[pos_s] = gnt[pos_s] | hit_s;
         idx        = hit_s ? IDX_W'(pos_s) : idx;
         valid      = valid | hit_s;
      end
   end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sequencer sharing one i2c_master port between N_REQ requesters.
// Optional watchdog and rsp_timeout port enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter
   import i2c_pkg::*;
#(
`ifdef I2C_ARB_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
`endif
   parameter int N_REQ = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req,
   input  logic [I2C_ADDR_W*N_REQ-1:0] req_addr,
   input  logic [N_REQ-1:0]            req_rw,
   input  logic [I2C_DATA_W*N_REQ-1:0] req_wr_data,
   output logic [N_REQ-1:0]            gnt,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [I2C_DATA_W-1:0]       rsp_rd_data,
   output logic                        rsp_ack_error,
`ifdef I2C_ARB_TIMEOUT_EN
   output logic                        rsp_timeout,
`endif
   output logic                        m_start,
   output logic [I2C_ADDR_W-1:0]       m_addr,
   output logic                        m_rw,
   output logic [I2C_DATA_W-1:0]       m_wr_data,
   input  logic [I2C_DATA_W-1:0]       m_rd_data,
   input  logic                        m_busy,
   input  logic                        m_done,
   input  logic                        m_ack_error
);

   localparam int IDX_W = idx_width(N_REQ);

   arb_state_e       state_r;
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] idx_r;
   logic [N_REQ-1:0] win_gnt_s;
   logic [IDX_W-1:0] win_idx_s;
   logic             win_valid_s;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int              WD_W   = idx_width(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0]            wd_r;
`endif

   rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
      .req   (req),
      .ptr   (ptr_r),
      .gnt   (win_gnt_s),
      .idx   (win_idx_s),
      .valid (win_valid_s)
   );

   // Transaction sequencer; every output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         ptr_r         <= {IDX_W{1'b0}};
         idx_r         <= {IDX_W{1'b0}};
         gnt           <= {N_REQ{1'b0}};
         rsp_valid     <= {N_REQ{1'b0}};
         rsp_rd_data   <= {I2C_DATA_W{1'b0}};
         rsp_ack_error <= 1'b0;
         m_start       <= 1'b0;
         m_addr        <= {I2C_ADDR_W{1'b0}};
         m_rw          <= 1'b0;
         m_wr_data     <= {I2C_DATA_W{1'b0}};
`ifdef I2C_ARB_TIMEOUT_EN
         rsp_timeout   <= 1'b0;
         wd_r          <= {WD_W{1'b0}};
`endif
      end else begin
         m_start     <= 1'b0;
         rsp_valid   <= {N_REQ{1'b0}};
`ifdef I2C_ARB_TIMEOUT_EN
         rsp_timeout <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               // Only start when the master is free, so a stale busy never overlaps.
               if (win_valid_s && !m_busy) begin
                  idx_r     <= win_idx_s;
                  gnt       <= win_gnt_s;
                  m_addr    <= req_addr[win_idx_s*I2C_ADDR_W +: I2C_ADDR_W];
                  m_rw      <= req_rw[win_idx_s];
                  m_wr_data <= req_wr_data[win_idx_s*I2C_DATA_W +: I2C_DATA_W];
                  m_start   <= 1'b1;
                  state_r   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
               wd_r    <= {WD_W{1'b0}};
`endif
               state_r <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
               if (m_done) begin
                  rsp_valid     <= gnt;
                  rsp_rd_data   <= m_rd_data;
                  rsp_ack_error <= m_ack_error;
                  state_r       <= ST_RESP;
               end else if ((state_r == ST_WAIT_BUSY) && m_busy) begin
                  state_r <= ST_WAIT_DONE;
               end
`ifdef I2C_ARB_TIMEOUT_EN
               if (!m_done) begin
                  if (wd_r == WD_MAX) begin
                     rsp_valid     <= gnt;
                     rsp_rd_data   <= {I2C_DATA_W{1'b0}};
                     rsp_ack_error <= 1'b1;
                     rsp_timeout   <= 1'b1;
                     state_r       <= ST_RESP;
                  end else begin
                     wd_r <= wd_r + WD_W'(1);
                  end
               end
`endif
            end
            ST_RESP: begin
               gnt     <= {N_REQ{1'b0}};
               ptr_r   <= (idx_r == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
               state_r <= ST_IDLE;
            end
            default: begin
               gnt     <= {N_REQ{1'b0}};
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
